// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, divisor table, parity modes and TX states.
// Used by the byte transmitter and the existing byte receiver.
package uart_pkg;

  localparam int DIV_W = 13;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  // Unused select codes fall back to 9600 so a bad strap still gives a usable line.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                input logic [2:0]  sel);
    int unsigned baud;
    case (sel)
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    return DIV_W'(clk_freq / baud - 1);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV while enabled and flags the wrap cycle with bit_tick.
// Held at zero when disabled so every frame starts on a full bit period.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] DIV,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;

  assign bit_tick = enable && (cnt == DIV);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (!enable || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Byte, baud select and parity are captured when a request is accepted and held for the frame.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PARITY   = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] Baud_Set,
  input  logic [7:0] Data,
  input  logic       Send_Go,
  output logic       uart_tx,
  output logic       Tx_Busy,
  output logic       Tx_Done
);

  localparam parity_t PAR_MODE = parity_t'(PARITY[1:0]);

  tx_state_t        state;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             par_bit;
  logic [DIV_W-1:0] div_q;
  logic             bit_tick;
  logic             accept;
  logic             shift_en;

  assign accept   = (state == S_IDLE) && Send_Go;
  assign shift_en = bit_tick && ((state == S_START) || (state == S_DATA));

  uart_baud_gen u_baud_gen (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .enable   (Tx_Busy),
    .DIV      (div_q),
    .bit_tick (bit_tick)
  );

  // Frame datapath: loaded on accept, shifted right as each data bit is launched.
  always_ff @(posedge Clk) begin
    if (accept) begin
      shift_q <= Data;
      par_bit <= (PAR_MODE == PAR_ODD) ? ~^Data : ^Data;
      div_q   <= baud_div(CLK_FREQ, Baud_Set);
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      uart_tx <= 1'b1;
      Tx_Busy <= 1'b0;
      Tx_Done <= 1'b0;
    end else begin
      Tx_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (Send_Go) begin
            uart_tx <= 1'b0;
            Tx_Busy <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_tick) begin
            uart_tx <= shift_q[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              if (PAR_MODE != PAR_NONE) begin
                uart_tx <= par_bit;
                state   <= S_PARITY;
              end else begin
                uart_tx <= 1'b1;
                state   <= S_STOP;
              end
            end else begin
              uart_tx <= shift_q[0];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            uart_tx <= 1'b1;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            Tx_Done <= 1'b1;
            Tx_Busy <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          Tx_Busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three instances (no/odd/even parity) decoded by a line receiver model.
// Expected frames are queued when a request is driven and checked when the line produces them.
module tb_uart_byte_tx;
  import uart_pkg::*;

  localparam int N115 = 434;
  localparam int N9600 = 5208;
  localparam int TMO = 2000;

  typedef struct {
    logic [7:0] data;
    int         n;
    int         par;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [2:0] Baud_Set = 3'd4;
  logic [7:0] Data = 8'h00;
  logic       go0 = 1'b0, go1 = 1'b0, go2 = 1'b0;
  logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;

  int cyc = 0;
  int dcnt0 = 0;
  int n_run = 0;
  int n_fail = 0;
  exp_t q0[$], q1[$], q2[$];
  logic fall_seen[3] = '{1'b0, 1'b0, 1'b0};
  int   fall_cyc[3]  = '{0, 0, 0};
  int   done_cyc[3]  = '{0, 0, 0};
  int   exp_div[8]   = '{5207, 2603, 1301, 867, 433, 5207, 5207, 5207};

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) if (done0) dcnt0 <= dcnt0 + 1;

  uart_byte_tx #(.CLK_FREQ(50_000_000), .PARITY(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Baud_Set(Baud_Set), .Data(Data), .Send_Go(go0),
    .uart_tx(tx0), .Tx_Busy(busy0), .Tx_Done(done0));
  uart_byte_tx #(.CLK_FREQ(50_000_000), .PARITY(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Baud_Set(Baud_Set), .Data(Data), .Send_Go(go1),
    .uart_tx(tx1), .Tx_Busy(busy1), .Tx_Done(done1));
  uart_byte_tx #(.CLK_FREQ(50_000_000), .PARITY(2)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Baud_Set(Baud_Set), .Data(Data), .Send_Go(go2),
    .uart_tx(tx2), .Tx_Busy(busy2), .Tx_Done(done2));

  task automatic check(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic done_of(input int s);
    case (s)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic set_go(input int s, input logic v);
    case (s)
      0:       go0 = v;
      1:       go1 = v;
      default: go2 = v;
    endcase
  endtask

  task automatic pulse(input int s);
    @(negedge Clk);
    set_go(s, 1'b1);
    @(negedge Clk);
    set_go(s, 1'b0);
  endtask

  task automatic push(input int s, input logic [7:0] d, input int n, input int par);
    exp_t e;
    e.data = d; e.n = n; e.par = par;
    case (s)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Receiver model; must be entered at a falling clock edge.
  task automatic rx(input int s);
    exp_t e;
    int c0, k, qsz;
    logic [7:0] b;
    logic pb;
    case (s)
      0:       qsz = q0.size();
      1:       qsz = q1.size();
      default: qsz = q2.size();
    endcase
    if (qsz == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    case (s)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (fall_seen[s]) begin
      c0 = fall_cyc[s];
      check("b2b_gap", c0 - done_cyc[s], 1);
      fall_seen[s] = 1'b0;
    end else begin
      k = 0;
      while (line(s) !== 1'b0 && k < TMO) begin
        @(negedge Clk);
        k++;
      end
      if (k >= TMO) begin
        check("fall_timeout", k, 0);
        return;
      end
      c0 = cyc;
    end
    repeat (e.n / 2) @(negedge Clk);
    check("start_bit", int'(line(s)), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (e.n) @(negedge Clk);
      b[i] = line(s);
    end
    if (e.par != 0) begin
      repeat (e.n) @(negedge Clk);
      pb = line(s);
      check("parity_bit", int'(pb), int'((e.par == 1) ? ~^e.data : ^e.data));
    end
    repeat (e.n) @(negedge Clk);
    check("stop_bit", int'(line(s)), 1);
    check("rx_data", int'(b), int'(e.data));
    k = 0;
    while (done_of(s) !== 1'b1 && k < e.n) begin
      @(negedge Clk);
      k++;
    end
    check("frame_len", cyc - c0, ((e.par != 0) ? 11 : 10) * e.n);
    done_cyc[s] = cyc;
    @(negedge Clk);
    check("done_width", int'(done_of(s)), 0);
    if (line(s) === 1'b0) begin
      fall_seen[s] = 1'b1;
      fall_cyc[s]  = cyc;
    end
  endtask

  initial begin
    int d, lows;

    for (int i = 0; i < 8; i++)
      check("baud_div", int'(baud_div(50_000_000, 3'(i))), exp_div[i]);

    repeat (3) @(negedge Clk);
    check("rst_tx", int'(tx0), 1);
    check("rst_busy", int'(busy0 | busy1 | busy2), 0);
    check("rst_done", int'(done0), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Asynchronous reset in the middle of data bit 3
    Baud_Set = 3'd4; Data = 8'hA5;
    pulse(0);
    check("rst_fall", int'(tx0), 0);
    repeat (4 * N115 + N115 / 2) @(negedge Clk);
    check("bit3_low", int'(tx0), 0);
    #1 Reset_n = 1'b0;
    #1;
    check("async_tx", int'(tx0), 1);
    check("async_busy", int'(busy0), 0);
    check("async_done", int'(done0), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    d = dcnt0; lows = 0;
    repeat (2 * N115) begin
      @(negedge Clk);
      if (tx0 === 1'b0) lows++;
    end
    check("post_rst_low", lows, 0);
    check("post_rst_done", dcnt0 - d, 0);
    check("post_rst_busy", int'(busy0), 0);

    // 0xA5 at 115200, single-cycle request
    d = dcnt0;
    push(0, 8'hA5, N115, 0);
    pulse(0);
    check("latency", int'(tx0), 0);
    check("busy_on", int'(busy0), 1);
    rx(0);
    check("a5_dones", dcnt0 - d, 1);
    check("busy_off", int'(busy0), 0);

    // 0x00 at 9600 on dut0 while parity frames run on dut1/dut2
    Baud_Set = 3'd0; Data = 8'h00;
    push(0, 8'h00, N9600, 0);
    pulse(0);
    fork
      rx(0);
      begin
        repeat (3) @(negedge Clk);
        Baud_Set = 3'd4; Data = 8'h01;
        push(1, 8'h01, N115, 1);
        pulse(1);
        rx(1);
        push(2, 8'h01, N115, 2);
        pulse(2);
        rx(2);
      end
    join

    // Re-requests and data change mid-frame are ignored
    Baud_Set = 3'd4; Data = 8'hFF;
    d = dcnt0;
    push(0, 8'hFF, N115, 0);
    pulse(0);
    fork
      rx(0);
      begin
        repeat (2 * N115) @(negedge Clk);
        pulse(0);
        Data = 8'h3C;
        repeat (N115) @(negedge Clk);
        pulse(0);
      end
    join
    check("repulse_fall", int'(fall_seen[0]), 0);
    lows = 0;
    repeat (2 * N115) begin
      @(negedge Clk);
      if (tx0 === 1'b0) lows++;
    end
    check("repulse_idle", lows, 0);
    check("repulse_dones", dcnt0 - d, 1);

    // Level-held request: three contiguous frames
    Data = 8'h55;
    d = dcnt0;
    for (int i = 0; i < 3; i++) push(0, 8'h55, N115, 0);
    @(negedge Clk);
    go0 = 1'b1;
    rx(0);
    rx(0);
    go0 = 1'b0;
    rx(0);
    check("held_stop", int'(fall_seen[0]), 0);
    check("held_dones", dcnt0 - d, 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #(20 * 150_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Serialises one 8-bit byte per request onto the UART line: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Transmit-side counterpart of the existing UART byte receiver; shares its Baud_Set encoding and 50 MHz system clock.
- Sits between the DSP result/command logic and the board TX pin.
- Request/acknowledge handshake: Send_Go in, Tx_Busy/Tx_Done out.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz, used for baud divisor constants.
- PARITY, 0, 0 = none (10-bit frame), 1 = odd, 2 = even (11-bit frame).

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous active-low reset.
- Baud_Set  input  3  baud select: 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200, 5..7 = 9600.
- Data  input  8  byte to send; sampled only on an accepted Send_Go.
- Send_Go  input  1  single-cycle or level send request.
- uart_tx  output  1  serial line, idle high.
- Tx_Busy  output  1  high while a frame is in progress.
- Tx_Done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - uart_tx = 1, Tx_Busy = 0, Tx_Done = 0; counters cleared; state IDLE.
  - A frame cut off by reset is abandoned, not resumed.
- Baud divisor: DIV = CLK_FREQ/baud - 1. At 50 MHz this gives 5207, 2603, 1301, 867, 433. Counter width is 13 bits.
- Bit period N = DIV+1 cycles.
- States: IDLE, START, DATA, PARITY (present only if PARITY != 0), STOP.
- IDLE:
  - uart_tx = 1.
  - Send_Go = 1 at a rising edge with Tx_Busy = 0 is accepted: latch Data and Baud_Set, compute the parity bit from the latched byte, set Tx_Busy = 1, drive uart_tx = 0 at that same edge, and go to START.
  - Latency: uart_tx falls 1 cycle after the Send_Go sample edge.
- Bit timing:
  - The baud counter counts 0..DIV, then wraps.
  - Each wrap advances to the next bit, and uart_tx is updated at that edge (registered output, glitch-free).
- DATA: 8 bits LSB first. A 3-bit index 0..7 advances on each wrap; after bit 7 go to PARITY or STOP.
- PARITY:
  - Odd: bit = ~^byte.
  - Even: bit = ^byte.
- STOP:
  - uart_tx = 1 for N cycles.
  - At the final wrap: Tx_Done = 1 for exactly one cycle, Tx_Busy = 0, state IDLE.
- Frame duration from the uart_tx falling edge to the Tx_Done edge: 10N cycles, or 11N cycles with parity.
- Send_Go while Tx_Busy = 1: ignored, no queueing.
- Data and Baud_Set changes mid-frame: no effect on the current frame.
- Back-to-back frames: Send_Go high during the Tx_Done cycle is accepted at the next edge. uart_tx then stays high 1 cycle longer than the stop bit (stop = N+1 cycles); that is legal.
- Level-held Send_Go sends continuously, one frame per accepted request.

Decomposition:
- Shared package uart_pkg:
  - baud-select constants BAUD_9600..BAUD_115200 (3-bit);
  - function baud_div(clk_freq, sel) returning the 13-bit DIV;
  - parity enum PAR_NONE/PAR_ODD/PAR_EVEN.
- The existing receiver's divisor table should migrate to this package.
- One sub-module, uart_baud_gen:
  - inputs: Clk, Reset_n, enable, DIV;
  - output: a one-cycle bit_tick on counter wrap;
  - counter held at 0 when disabled.
- uart_byte_tx instantiates uart_baud_gen and holds the FSM, shift register and bit index.

Test Plan:
- Reset mid-frame at 115200: assert Reset_n low during bit 3 -> uart_tx = 1, Tx_Busy = 0 immediately (asynchronous). After release, no Tx_Done and a clean idle line.
- Baud_Set = 4, Data = 0xA5, one-cycle Send_Go -> uart_tx falls 1 cycle later, each bit is 434 cycles, line sequence 0,1,0,1,0,0,1,0,1,1, Tx_Done pulses once 4340 cycles after the fall.
- Baud_Set = 0, Data = 0x00, checked with the existing receiver in loopback at Baud_Set = 0 -> bit period 5208 cycles, receiver Rx_Done with Data = 0x00.
- Send_Go re-pulsed mid-frame with Data = 0xFF, then Data changed to 0x3C -> first frame completes unchanged, no second frame, exactly one Tx_Done.
- Send_Go held high for 3 frames, Data = 0x55, Baud_Set = 4 -> 3 contiguous frames, each 4340 cycles, stop bits of frames 1-2 lasting 435 cycles, 3 Tx_Done pulses; receiver loopback yields 0x55 ×3.
- PARITY = 1, Data = 0x01 (one set bit) -> parity bit 0, frame 4774 cycles. With PARITY = 2 -> parity bit 1.
